// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Latency: none (types only); backpressure: n/a.
package if_prefetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } pf_entry_t;

  // Pointer width for an n-entry ring; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Reservation FIFO: reserve at tail on issue, fill oldest unfilled on response, pop head, flush.
// Latency: fill visible at head the cycle after; backpressure: caller must not reserve when full.
module if_prefetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   reserve_i,
  input  logic [31:0]            reserve_pc_i,
  input  logic                   fill_i,
  input  logic [31:0]            fill_inst_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output pf_entry_t              head_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  pf_entry_t         mem_q [DEPTH];
  pf_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     count_q, count_d;

  // Reserve, fill and pop never touch the same slot: fill targets a reserved
  // unfilled entry, pop only a filled head, reserve only a free tail.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i].filled = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else begin
      if (reserve_i) begin
        mem_d[tail_q] = '{pc: reserve_pc_i, inst: NOP_INST, filled: 1'b0};
        tail_d        = tail_q + PW'(1);
      end
      if (fill_i) begin
        mem_d[fill_q].inst   = fill_inst_i;
        mem_d[fill_q].filled = 1'b1;
        fill_d               = fill_q + PW'(1);
      end
      if (pop_i) begin
        mem_d[head_q].filled = 1'b0;
        head_d               = head_q + PW'(1);
      end
      count_d = count_q + CW'(reserve_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/if_prefetch_buffer.sv
// Fetch PC owner and prefetch buffer to IF/ID; min latency imem latency+1, valid/ready to IF/ID.
// Optional IF_PREFETCH_PERF_EN adds saturating issued/dropped counters.
module if_prefetch_buffer
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        inst_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_issued_o,
  output logic [31:0] perf_dropped_o
`endif
);

  localparam int            OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_count;
  pf_entry_t     head;
  logic          req_accept, rsp_drop, rsp_fill, pop;

  assign imem_req_valid_o = rst_n & ~redirect_i & (fifo_count < FULL) & (outstanding_q < MAX_OS);
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_accept       = imem_req_valid_o & imem_req_ready_i;
  assign rsp_drop         = imem_rsp_valid_i & (drop_cnt_q != '0);
  assign rsp_fill         = imem_rsp_valid_i & (drop_cnt_q == '0) & ~redirect_i;
  assign pop              = inst_valid_o & inst_ready_i & ~redirect_i;

  // After a redirect every request still in flight belongs to the old path,
  // so the drop count becomes whatever remains outstanding after this cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OW'(req_accept) - OW'(imem_rsp_valid_i);
    drop_cnt_d    = drop_cnt_q - OW'(rsp_drop);
    if (req_accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      drop_cnt_d = outstanding_q - OW'(imem_rsp_valid_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  if_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_i),
    .reserve_i    (req_accept),
    .reserve_pc_i (fetch_pc_q),
    .fill_i       (rsp_fill),
    .fill_inst_i  (imem_rsp_data_i),
    .pop_i        (pop),
    .count_o      (fifo_count),
    .head_o       (head)
  );

  assign inst_valid_o = head.filled;
  assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
  assign pc_o         = inst_valid_o ? head.pc : 32'h0;

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] dropped_q, dropped_d;
  logic        rsp_discard;

  assign rsp_discard = imem_rsp_valid_i & ((drop_cnt_q != '0) | redirect_i);

  always_comb begin
    issued_d  = issued_q;
    dropped_d = dropped_q;
    if (req_accept && issued_q != '1) issued_d = issued_q + 32'd1;
    if (rsp_discard && dropped_q != '1) dropped_d = dropped_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
    end
  end

  assign perf_issued_o  = issued_q;
  assign perf_dropped_o = dropped_q;
`endif

  rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed bench for if_prefetch_buffer with an in-order, fixed-latency imem model.
module tb_if_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_ready_i = 1'b1;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_issued_o;
  logic [31:0] perf_dropped_o;
  logic [31:0] s_pi, s_pd;
`endif

  if_prefetch_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_ready_i     (inst_ready_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .pc_o             (pc_o)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_issued_o    (perf_issued_o),
    .perf_dropped_o   (perf_dropped_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rq_t;

  rq_t         q[$];
  int          cyc, lat, n_acc;
  int          n_chk, n_bad;
  logic        s_req_vld, s_inst_vld;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive the due response, snapshot outputs, record an accept.
  task automatic cycle();
    rq_t r;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = ~q[0].addr;
      void'(q.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    s_req_vld  = imem_req_valid_o;
    s_addr     = imem_req_addr_o;
    s_inst_vld = inst_valid_o;
    s_inst     = inst_o;
    s_pc       = pc_o;
`ifdef IF_PREFETCH_PERF_EN
    s_pi = perf_issued_o;
    s_pd = perf_dropped_o;
`endif
    if (imem_req_valid_o && imem_req_ready_i) begin
      r.addr = imem_req_addr_o;
      r.due  = cyc + lat;
      q.push_back(r);
      n_acc++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    q.delete();
    imem_rsp_valid_i = 1'b0;
    redirect_i       = 1'b0;
    #1;
    chk("rst_req_vld", {31'b0, imem_req_valid_o}, 32'd0);
    chk("rst_inst_vld", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    n_acc = 0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    @(negedge clk);

    // Reset release and streaming with a 1-cycle imem.
    lat = 1;
    do_reset();
    cycle();
    chk("t1_c0_req_vld", {31'b0, s_req_vld}, 32'd1);
    chk("t1_c0_addr", s_addr, 32'h0);
    chk("t1_c0_inst_vld", {31'b0, s_inst_vld}, 32'd0);
    chk("t1_c0_inst", s_inst, 32'h0000_0013);
    cycle();
    chk("t1_c1_inst_vld", {31'b0, s_inst_vld}, 32'd0);
    chk("t1_c1_inst", s_inst, 32'h0000_0013);
    chk("t1_c1_addr", s_addr, 32'h4);
    for (int k = 2; k < 6; k++) begin
      cycle();
      chk("t2_inst_vld", {31'b0, s_inst_vld}, 32'd1);
      chk("t2_pc", s_pc, 32'(4 * (k - 2)));
      chk("t2_inst", s_inst, ~32'(4 * (k - 2)));
      chk("t2_addr", s_addr, 32'(4 * k));
    end

    // Consumer stalled for 10 cycles: buffer fills to DEPTH and holds.
    do_reset();
    inst_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    chk("t3_accepts", 32'(n_acc), 32'd4);
    chk("t3_req_vld", {31'b0, s_req_vld}, 32'd0);
    chk("t3_inst_vld", {31'b0, s_inst_vld}, 32'd1);
    chk("t3_pc_held", s_pc, 32'h0);
    inst_ready_i = 1'b1;
    cycle();
    chk("t3_pop_pc0", s_pc, 32'h0);
    chk("t3_no_bypass", {31'b0, s_req_vld}, 32'd0);
    cycle();
    chk("t3_pc4", s_pc, 32'h4);
    chk("t3_req_after_pop", {31'b0, s_req_vld}, 32'd1);
    chk("t3_addr10", s_addr, 32'h10);
    cycle();
    chk("t3_pc8", s_pc, 32'h8);
    cycle();
    chk("t3_pcc", s_pc, 32'hC);
    cycle();
    chk("t3_pc10", s_pc, 32'h10);
    chk("t3_inst10", s_inst, ~32'h10);

    // Redirect with two live requests on a 3-cycle imem.
    lat = 3;
    do_reset();
    cycle();
    cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    cycle();
    chk("t4_redir_req_vld", {31'b0, s_req_vld}, 32'd0);
    redirect_i = 1'b0;
    cycle();
    chk("t4_c3_inst_vld", {31'b0, s_inst_vld}, 32'd0);
    chk("t4_c3_req_vld", {31'b0, s_req_vld}, 32'd0);
    cycle();
    chk("t4_c4_addr", s_addr, 32'h100);
    chk("t4_c4_req_vld", {31'b0, s_req_vld}, 32'd1);
    cycle();
    cycle();
    cycle();
    chk("t4_c7_inst_vld", {31'b0, s_inst_vld}, 32'd0);
    cycle();
    chk("t4_c8_inst_vld", {31'b0, s_inst_vld}, 32'd1);
    chk("t4_c8_pc", s_pc, 32'h100);
    chk("t4_c8_inst", s_inst, ~32'h100);
    cycle();
    chk("t4_c9_pc", s_pc, 32'h104);
`ifdef IF_PREFETCH_PERF_EN
    chk("t6_perf_issued", s_pi, 32'd5);
    chk("t6_perf_dropped", s_pd, 32'd2);
`endif

    // Redirect coinciding with a live response and a pop; PC wrap.
    lat = 1;
    do_reset();
    cycle();
    cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    chk("t5_c2_inst_vld", {31'b0, s_inst_vld}, 32'd1);
    chk("t5_c2_req_vld", {31'b0, s_req_vld}, 32'd0);
    redirect_i = 1'b0;
    cycle();
    chk("t5_c3_inst_vld", {31'b0, s_inst_vld}, 32'd0);
    chk("t5_c3_req_vld", {31'b0, s_req_vld}, 32'd1);
    chk("t5_c3_addr", s_addr, 32'hFFFF_FFFC);
    cycle();
    chk("t5_c4_wrap_addr", s_addr, 32'h0);
    chk("t5_c4_inst_vld", {31'b0, s_inst_vld}, 32'd0);
    cycle();
    chk("t5_c5_inst_vld", {31'b0, s_inst_vld}, 32'd1);
    chk("t5_c5_pc", s_pc, 32'hFFFF_FFFC);
    chk("t5_c5_inst", s_inst, 32'h3);
    cycle();
    chk("t5_c6_pc", s_pc, 32'h0);

    // Reset in the middle of streaming discards everything.
    do_reset();
    cycle();
    chk("t7_inst_vld", {31'b0, s_inst_vld}, 32'd0);
    chk("t7_addr", s_addr, 32'h0);
`ifdef IF_PREFETCH_PERF_EN
    chk("t7_perf_issued", s_pi, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
